// File: rtl/conv_mem_pkg.sv
// State encodings and default sizing shared by the convolver line-buffer sequencer.
package conv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_PROC = 2'b10,
    ST_READ = 2'b11
  } seqState_e;

  localparam int DEF_NB_ADDRESS   = 10;
  localparam int DEF_NB_IMAGE     = 10;
  localparam int DEF_NB_BLOCK     = 8;
  localparam int DEF_CONV_LATENCY = 6;
  localparam int DEF_KERNEL_SIZE  = 3;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/valid_edge_det.sv
// Registered rising-edge detector for the host data strobe.
module valid_edge_det (
  input  logic i_CLK,
  input  logic i_reset,
  input  logic i_valid,
  output logic o_edge
);

  logic vldQ;

  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      vldQ <= 1'b0;
    end else begin
      vldQ <= i_valid;
    end
  end

  assign o_edge = i_valid & ~vldQ;

endmodule

// File: rtl/conv_mem_seq_ctrl.sv
// Address sequencer for the convolver line-buffer memories (LOAD, PROC, READ-back phases).
// Define CONV_STALL_EN to add i_stall, which freezes the PROC counters and masks the convolver valid.
module conv_mem_seq_ctrl
  import conv_mem_pkg::*;
#(
  parameter int NB_ADDRESS   = DEF_NB_ADDRESS,
  parameter int NB_IMAGE     = DEF_NB_IMAGE,
  parameter int NB_BLOCK     = DEF_NB_BLOCK,
  parameter int CONV_LATENCY = DEF_CONV_LATENCY,
  parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic [NB_IMAGE-1:0]   i_imgLength,
  input  logic [NB_BLOCK-1:0]   i_blocks,
  input  logic                  i_load,
  input  logic                  i_SoP,
`ifdef CONV_STALL_EN
  input  logic                  i_stall,
`endif
  input  logic                  i_valid,
  output logic [NB_ADDRESS-1:0] o_writeAdd,
  output logic [NB_ADDRESS-1:0] o_readAdd,
  output logic                  o_EoP,
  output logic                  o_changeBlock,
  output logic                  o_fms2conVld,
  output logic [1:0]            o_state,
  output logic [NB_BLOCK-1:0]   o_blockCnt,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int NB_CMP = maxInt(NB_ADDRESS, NB_IMAGE) + 1;

  seqState_e             state, stateNext;
  logic [NB_ADDRESS-1:0] rdCnt, rdNext;
  logic [NB_ADDRESS-1:0] wrCnt, wrNext;
  logic [NB_IMAGE-1:0]   imgLen, imgLenNext;
  logic [NB_BLOCK-1:0]   blocks, blocksNext;
  logic [NB_BLOCK-1:0]   blockCnt, blockCntNext;
  logic                  loaded, loadedNext;
  logic                  eop, eopNext;
  logic                  changeBlock, changeBlockNext;
  logic                  fmsVld, fmsVldNext;
  logic                  done, doneNext;
  logic                  err, errNext;

  logic                  validEdge;
  logic                  stall;
  logic                  procStall;
  logic [NB_CMP-1:0]     rdExt, wrExt, hExt, lastWr;
  logic [NB_IMAGE:0]     lastWrImg;
  logic [NB_BLOCK:0]     blockInc;
  logic                  rdAtEnd, wrAtEnd, kernelFits;

  valid_edge_det uEdge (
    .i_CLK   (i_CLK),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_edge  (validEdge)
  );

`ifdef CONV_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif

  assign procStall = stall && (state == ST_PROC);

  // Last write address is H-(KERNEL_SIZE-1); the IDLE guard keeps it from going negative.
  assign lastWrImg  = {1'b0, imgLen} - (NB_IMAGE+1)'(KERNEL_SIZE - 1);
  assign lastWr     = NB_CMP'(lastWrImg);
  assign rdExt      = NB_CMP'(rdCnt);
  assign wrExt      = NB_CMP'(wrCnt);
  assign hExt       = NB_CMP'(imgLen);
  assign rdAtEnd    = (rdExt == hExt);
  assign wrAtEnd    = (wrExt == lastWr);
  assign kernelFits = (hExt >= NB_CMP'(KERNEL_SIZE - 1));
  assign blockInc   = {1'b0, blockCnt} + 1'b1;

  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      rdCnt       <= '0;
      wrCnt       <= '0;
      imgLen      <= '0;
      blocks      <= '0;
      blockCnt    <= '0;
      loaded      <= 1'b0;
      eop         <= 1'b0;
      changeBlock <= 1'b0;
      fmsVld      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= stateNext;
      rdCnt       <= rdNext;
      wrCnt       <= wrNext;
      imgLen      <= imgLenNext;
      blocks      <= blocksNext;
      blockCnt    <= blockCntNext;
      loaded      <= loadedNext;
      eop         <= eopNext;
      changeBlock <= changeBlockNext;
      fmsVld      <= fmsVldNext;
      done        <= doneNext;
      err         <= errNext;
    end
  end

  always_comb begin
    stateNext       = state;
    rdNext          = rdCnt;
    wrNext          = wrCnt;
    imgLenNext      = imgLen;
    blocksNext      = blocks;
    blockCntNext    = blockCnt;
    loadedNext      = loaded;
    eopNext         = eop;
    fmsVldNext      = fmsVld;
    doneNext        = done;
    changeBlockNext = 1'b0;
    errNext         = 1'b0;

    case (state)
      ST_IDLE: begin
        rdNext     = '0;
        wrNext     = '0;
        fmsVldNext = 1'b0;
        if (i_load && i_SoP) begin
          errNext = 1'b1;
        end else if (i_load) begin
          imgLenNext = i_imgLength;
          blocksNext = i_blocks;
          doneNext   = 1'b0;
          stateNext  = ST_LOAD;
        end else if (i_SoP) begin
          if (loaded && kernelFits) begin
            fmsVldNext = 1'b1;
            stateNext  = ST_PROC;
          end else begin
            errNext = 1'b1;
          end
        end else if (eop) begin
          stateNext = ST_READ;
        end
      end

      // LOAD and READ share the strobe-driven address walk; only the completion bookkeeping differs.
      ST_LOAD, ST_READ: begin
        if (rdAtEnd) begin
          if (!i_load) begin
            changeBlockNext = 1'b1;
            stateNext       = ST_IDLE;
            if (state == ST_LOAD) begin
              loadedNext = 1'b1;
            end else begin
              eopNext = 1'b0;
              if (blockInc == {1'b0, blocks}) begin
                doneNext     = 1'b1;
                blockCntNext = '0;
              end else begin
                blockCntNext = blockInc[NB_BLOCK-1:0];
              end
            end
          end
        end else if (validEdge && (rdExt < hExt)) begin
          rdNext = rdCnt + 1'b1;
        end
      end

      ST_PROC: begin
        if (!procStall) begin
          if (rdExt < hExt) begin
            rdNext = rdCnt + 1'b1;
          end
          if ((rdExt >= NB_CMP'(CONV_LATENCY)) && (wrExt < lastWr)) begin
            wrNext = wrCnt + 1'b1;
          end
          if (wrAtEnd) begin
            fmsVldNext = 1'b0;
            if (!i_SoP) begin
              eopNext    = 1'b1;
              loadedNext = 1'b0;
              stateNext  = ST_IDLE;
            end
          end
        end
      end

      default: stateNext = ST_IDLE;
    endcase
  end

  assign o_readAdd     = rdCnt;
  assign o_writeAdd    = (state == ST_PROC) ? wrCnt : rdCnt;
  assign o_EoP         = eop;
  assign o_changeBlock = changeBlock;
  assign o_fms2conVld  = fmsVld & ~procStall;
  assign o_state       = state;
  assign o_blockCnt    = blockCnt;
  assign o_done        = done;
  assign o_err         = err;

endmodule

// File: tb/tb_conv_mem_seq_ctrl.sv
// Directed bench for conv_mem_seq_ctrl: command decode, LOAD/PROC/READ timing, block counting, async reset.
module tb_conv_mem_seq_ctrl;

  localparam int NB_ADDRESS = 10;
  localparam int NB_IMAGE   = 10;
  localparam int NB_BLOCK   = 8;
  localparam int LAT        = 6;
  localparam int KS         = 3;
  localparam int H          = 10;

  logic                  iClk = 1'b0;
  logic                  iReset = 1'b1;
  logic [NB_IMAGE-1:0]   imgLength;
  logic [NB_BLOCK-1:0]   blocks;
  logic                  load, sop, valid;
`ifdef CONV_STALL_EN
  logic                  stall = 1'b0;
`endif
  logic [NB_ADDRESS-1:0] writeAdd, readAdd;
  logic                  eop, changeBlock, fmsVld, done, err;
  logic [1:0]            state;
  logic [NB_BLOCK-1:0]   blockCnt;

  int testsRun = 0;
  int testsFailed = 0;

  conv_mem_seq_ctrl dut (
    .i_CLK         (iClk),
    .i_reset       (iReset),
    .i_imgLength   (imgLength),
    .i_blocks      (blocks),
    .i_load        (load),
    .i_SoP         (sop),
`ifdef CONV_STALL_EN
    .i_stall       (stall),
`endif
    .i_valid       (valid),
    .o_writeAdd    (writeAdd),
    .o_readAdd     (readAdd),
    .o_EoP         (eop),
    .o_changeBlock (changeBlock),
    .o_fms2conVld  (fmsVld),
    .o_state       (state),
    .o_blockCnt    (blockCnt),
    .o_done        (done),
    .o_err         (err)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic sp, input logic vl);
    load  = ld;
    sop   = sp;
    valid = vl;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "State"}, int'(state), 0);
    checkOutput({tag, "ReadAdd"}, int'(readAdd), 0);
    checkOutput({tag, "WriteAdd"}, int'(writeAdd), 0);
    checkOutput({tag, "EoP"}, int'(eop), 0);
    checkOutput({tag, "Chg"}, int'(changeBlock), 0);
    checkOutput({tag, "Fms"}, int'(fmsVld), 0);
    checkOutput({tag, "BlkCnt"}, int'(blockCnt), 0);
    checkOutput({tag, "Done"}, int'(done), 0);
    checkOutput({tag, "Err"}, int'(err), 0);
  endtask

  task automatic runLoad(input int h, input int nBlk);
    imgLength = NB_IMAGE'(h);
    blocks    = NB_BLOCK'(nBlk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("loadEnter", int'(state), 1);
    checkOutput("loadDoneClr", int'(done), 0);
    for (int i = 1; i <= h; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      step(1);
      checkOutput("loadAdd", int'(readAdd), i);
      applyStimulus(1'b1, 1'b0, 1'b0);
      step(1);
    end
    // an extra strobe at the last row must not move the address
    applyStimulus(1'b1, 1'b0, 1'b1);
    step(1);
    checkOutput("loadAddSat", int'(readAdd), h);
    checkOutput("loadHold", int'(state), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("loadChg", int'(changeBlock), 1);
    checkOutput("loadExit", int'(state), 0);
    step(1);
    checkOutput("loadChgPulse", int'(changeBlock), 0);
  endtask

  task automatic runProc(input int h);
    int last;
    int expRd;
    int expWr;
    last = h - (KS - 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("procEnter", int'(state), 2);
    checkOutput("procFmsOn", int'(fmsVld), 1);
    checkOutput("procRd0", int'(readAdd), 0);
    for (int k = 1; k <= LAT + last + 2; k++) begin
      step(1);
      expRd = (k < h) ? k : h;
      expWr = (k > LAT) ? (((k - LAT) < last) ? (k - LAT) : last) : 0;
      checkOutput("procRd", int'(readAdd), expRd);
      checkOutput("procWr", int'(writeAdd), expWr);
      checkOutput("procFms", int'(fmsVld), (k <= LAT + last) ? 1 : 0);
      checkOutput("procState", int'(state), 2);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("procEoP", int'(eop), 1);
    checkOutput("procExit", int'(state), 0);
  endtask

  task automatic runRead(input int h, input int expBlk, input int expDone);
    step(1);
    checkOutput("readEnter", int'(state), 3);
    for (int i = 1; i <= h; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      step(1);
      checkOutput("readAdd", int'(readAdd), i);
      checkOutput("readWrAdd", int'(writeAdd), i);
      applyStimulus(1'b0, 1'b0, 1'b0);
      step(1);
      if (i < h) checkOutput("readState", int'(state), 3);
    end
    checkOutput("readExit", int'(state), 0);
    checkOutput("readChg", int'(changeBlock), 1);
    checkOutput("readEoPClr", int'(eop), 0);
    checkOutput("readBlkCnt", int'(blockCnt), expBlk);
    checkOutput("readDone", int'(done), expDone);
    step(1);
    checkOutput("readChgPulse", int'(changeBlock), 0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    imgLength = '0;
    blocks    = '0;
    #1 iReset = 1'b0;
    #2 checkAllZero("rst");
    #9 iReset = 1'b1;
    step(1);
    checkOutput("idleState", int'(state), 0);

    // simultaneous commands are rejected
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(1);
    checkOutput("conflictErr", int'(err), 1);
    checkOutput("conflictState", int'(state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("conflictErrPulse", int'(err), 0);

    // start-of-process without any loaded image
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("noLoadErr", int'(err), 1);
    checkOutput("noLoadState", int'(state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("noLoadErrPulse", int'(err), 0);

    // image too short for the kernel
    runLoad(1, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("shortErr", int'(err), 1);
    checkOutput("shortState", int'(state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);

    // two full blocks
    runLoad(H, 2);
    runProc(H);
    runRead(H, 1, 0);
    runLoad(H, 2);
    runProc(H);
    runRead(H, 0, 1);

    // a new load clears done; then abort PROC with an asynchronous reset
    runLoad(H, 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    step(4);
    checkOutput("preRstRd", int'(readAdd), 4);
    #3 iReset = 1'b0;
    #1 checkAllZero("midRst");
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    iReset = 1'b1;
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("postRstErr", int'(err), 1);
    checkOutput("postRstState", int'(state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);

`ifdef CONV_STALL_EN
    runLoad(H, 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    step(7);
    checkOutput("stallPreRd", int'(readAdd), 7);
    stall = 1'b1;
    #1 checkOutput("stallFmsMask", int'(fmsVld), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkOutput("stallRd", int'(readAdd), 7);
      checkOutput("stallWr", int'(writeAdd), 1);
      checkOutput("stallFms", int'(fmsVld), 0);
    end
    stall = 1'b0;
    #1 checkOutput("stallFmsResume", int'(fmsVld), 1);
    step(7);
    checkOutput("stallLateRd", int'(readAdd), 10);
    checkOutput("stallLateWr", int'(writeAdd), 8);
    checkOutput("stallLateFms", int'(fmsVld), 1);
    step(1);
    checkOutput("stallFmsOff", int'(fmsVld), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("stallEoP", int'(eop), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/conv_mem_seq_ctrl.md
Name: conv_mem_seq_ctrl

Overview:
- Parametrised next-generation sequencer for the line-buffer memories feeding the 2D convolver.
- Generates read and write addresses for three phases: host LOAD, convolution PROC, host READ-back.
- Over the previous controller it adds configurable kernel size and convolver latency, a multi-block counter with completion flag, command-conflict error reporting, and an optional stall.
- Sits between the host/micro interface and the memory bank/convolver pair.

Parameters:
- NB_ADDRESS, 10, address width of read/write ports.
- NB_IMAGE, 10, width of image-height field.
- NB_BLOCK, 8, width of block counter and block-count input.
- CONV_LATENCY, 6, read-address count after which convolver outputs become valid.
- KERNEL_SIZE, 3, kernel rows; output rows lost = KERNEL_SIZE-1.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_imgLength  in  NB_IMAGE  last row index H; captured when a command is accepted in IDLE.
- i_blocks  in  NB_BLOCK  blocks per image; captured with i_imgLength.
- i_load  in  1  load command / level held during LOAD.
- i_SoP  in  1  start-of-process command / level held during PROC.
- i_valid  in  1  host data strobe; rising edge advances LOAD/READ address.
- o_writeAdd  out  NB_ADDRESS  memory write address.
- o_readAdd  out  NB_ADDRESS  memory read address.
- o_EoP  out  1  processing done, read-back pending.
- o_changeBlock  out  1  one-cycle pulse at end of LOAD or READ block.
- o_fms2conVld  out  1  convolver input valid.
- o_state  out  2  current state.
- o_blockCnt  out  NB_BLOCK  completed READ blocks.
- o_done  out  1  sticky; all blocks read back.
- o_err  out  1  one-cycle pulse on rejected command.

Behaviour:
- Reset (async, i_reset=0): all registers and outputs 0, state IDLE, loaded flag 0, edge-detect history 0. Reset asserted mid-operation aborts immediately; no partial pulses are emitted.
- State encoding: IDLE=00, LOAD=01, PROC=10, READ=11.
- Edge detect: vld_q <= i_valid every cycle. Edge = i_valid & ~vld_q.
- Address counters: rd_cnt and wr_cnt. o_readAdd = rd_cnt. o_writeAdd = wr_cnt in PROC, else rd_cnt.
- IDLE: counters cleared, o_fms2conVld=0. Decode by priority:
  - i_load & i_SoP: o_err pulse, stay IDLE.
  - i_load only: capture H and blocks, go LOAD.
  - i_SoP only with loaded flag set and H >= KERNEL_SIZE-1: go PROC, o_fms2conVld=1 next cycle.
  - i_SoP otherwise: o_err pulse, stay IDLE.
  - Neither command with o_EoP=1: go READ.
  - Else stay IDLE.
- LOAD: rd_cnt += 1 on edge while rd_cnt < H.
  - At rd_cnt==H and i_load=0: o_changeBlock pulse, set loaded flag, return to IDLE.
  - At rd_cnt==H with i_load still 1: hold.
- PROC: rd_cnt += 1 every cycle until H, then holds.
  - wr_cnt += 1 each cycle while rd_cnt >= CONV_LATENCY and wr_cnt < H-(KERNEL_SIZE-1).
  - When wr_cnt == H-(KERNEL_SIZE-1): o_fms2conVld <= 0.
  - If additionally i_SoP=0: o_EoP <= 1, clear loaded flag, return to IDLE. Otherwise hold.
  - Arithmetic: the subtraction is evaluated at NB_IMAGE+1 bits. Underflow is prevented by the IDLE check.
- READ: address advance identical to LOAD.
  - At rd_cnt==H and i_load=0: o_changeBlock pulse, o_EoP <= 0, o_blockCnt += 1, return to IDLE.
  - If o_blockCnt+1 == captured blocks: o_done <= 1 and o_blockCnt wraps to 0.
  - o_done clears on the next accepted LOAD command.
- Edge case: i_valid edges arriving when rd_cnt==H are ignored; no address wrap occurs.

Optional Feature:
- Macro: CONV_STALL_EN.
- Defined: adds input i_stall (1 bit). While i_stall=1 in PROC, rd_cnt and wr_cnt hold and o_fms2conVld is forced 0. On release, both counters and o_fms2conVld resume from their held values.
- Not defined: no port; PROC never stalls.

Decomposition:
- Package conv_mem_pkg: state encodings (ST_IDLE, ST_LOAD, ST_PROC, ST_READ), default widths, and the CONV_LATENCY/KERNEL_SIZE defaults.
- One sub-module, valid_edge_det: registered rising-edge detector with async active-low reset.

Test Plan:
- H=10, LOAD with 10 i_valid pulses then i_load low -> o_readAdd 0..10, one o_changeBlock pulse, state back to 00.
- After LOAD, i_SoP held -> o_readAdd counts 0..10 one per cycle; wr_cnt=1 the cycle after readAdd=6; o_writeAdd reaches 8 at cycle 14 after entry; o_fms2conVld falls at cycle 15; drop i_SoP -> o_EoP=1, IDLE.
- i_load and i_SoP asserted together in IDLE -> o_err single-cycle pulse, state stays 00. i_SoP without prior LOAD -> o_err.
- blocks=2, two full LOAD/PROC/READ sequences -> o_blockCnt 1 then wraps to 0, o_done=1 after second READ.
- i_reset=0 asynchronously mid-PROC at readAdd=4 -> all outputs 0 before the next clock edge, state 00.
- CONV_STALL_EN defined, i_stall=1 for 3 cycles at readAdd=7 -> readAdd/writeAdd frozen, o_fms2conVld=0; completion delayed exactly 3 cycles.
